// File: rtl/fetch_sequencer.sv
// Instruction-fetch control: owns the PC and shares the single imem port between loader writes and PC reads.
// Optional macro FETCH_BOUNDS_CHECK_EN: a PC update at or beyond IMEM_DEPTH traps into a sticky FAULT state.
module fetch_sequencer #(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       JUMP_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(32'h20),
  parameter int unsigned       IMEM_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              start,
  input  logic              halt_req,
  input  logic              stall,
  input  logic              jump_valid,
  input  logic [JUMP_W-1:0] jump_to,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_valid,
  output logic              flush,
  output logic [1:0]        state,
  output logic              fault
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_RUN   = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic              fetch_valid_r;
  logic              flush_r;
  logic [ADDR_W-1:0] jump_tgt_s;
  logic [ADDR_W-1:0] pc_inc_s;

  assign jump_tgt_s = ADDR_W'(jump_to);
  assign pc_inc_s   = pc_r + ADDR_W'(1'b1);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(IMEM_DEPTH);

  logic fault_r;

  function automatic logic out_of_bounds(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} >= DEPTH_L);
  endfunction

  assign fault = fault_r;
`else
  assign fault = 1'b0;
`endif

  // Memory port ownership: the loader drives the address only while loading
  always_comb begin
    ld_ready = 1'b0;
    mem_addr = pc_r;
    if (state_r == ST_LOAD) begin
      ld_ready = 1'b1;
      mem_addr = ld_addr;
    end else begin
      ld_ready = 1'b0;
      mem_addr = pc_r;
    end
  end

  assign mem_we      = ld_valid & ld_ready;
  assign mem_wdata   = ld_data;
  assign pc          = pc_r;
  assign fetch_valid = fetch_valid_r;
  assign flush       = flush_r;
  assign state       = state_r;

  // Sequencer FSM with PC and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      pc_r          <= RESET_VEC;
      fetch_valid_r <= 1'b0;
      flush_r       <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_r       <= 1'b0;
`endif
    end else begin
      flush_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          fetch_valid_r <= 1'b0;
          // The beat that wakes us up is not accepted here; it is taken in LOAD
          if (ld_valid) begin
            state_r <= ST_LOAD;
          end else if (start) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_VEC;
            fetch_valid_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (ld_valid && ld_last) begin
            state_r       <= ST_RUN;
            pc_r          <= RESET_VEC;
            fetch_valid_r <= 1'b1;
          end else begin
            state_r       <= ST_LOAD;
            fetch_valid_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (halt_req) begin
            state_r       <= ST_IDLE;
            fetch_valid_r <= 1'b0;
          end else if (jump_valid) begin
`ifdef FETCH_BOUNDS_CHECK_EN
            if (out_of_bounds(jump_tgt_s)) begin
              state_r       <= ST_FAULT;
              fault_r       <= 1'b1;
              fetch_valid_r <= 1'b0;
            end else begin
              pc_r          <= jump_tgt_s;
              flush_r       <= 1'b1;
              fetch_valid_r <= 1'b0;
            end
`else
            pc_r          <= jump_tgt_s;
            flush_r       <= 1'b1;
            fetch_valid_r <= 1'b0;
`endif
          end else if (stall) begin
            pc_r          <= pc_r;
            fetch_valid_r <= fetch_valid_r;
          end else begin
`ifdef FETCH_BOUNDS_CHECK_EN
            if (out_of_bounds(pc_inc_s)) begin
              state_r       <= ST_FAULT;
              fault_r       <= 1'b1;
              fetch_valid_r <= 1'b0;
            end else begin
              pc_r          <= pc_inc_s;
              fetch_valid_r <= 1'b1;
            end
`else
            pc_r          <= pc_inc_s;
            fetch_valid_r <= 1'b1;
`endif
          end
        end
        ST_FAULT: begin
          fetch_valid_r <= 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
          state_r <= ST_FAULT;
          fault_r <= 1'b1;
`else
          state_r <= ST_IDLE;
`endif
        end
        default: begin
          state_r       <= ST_IDLE;
          fetch_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: expected fetches and memory writes are queued by the stimulus
// and popped by a monitor whenever the DUT shows fetch_valid or mem_we; state/flag checks are direct.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_valid, ld_last, start, halt_req, stall, jump_valid;
  logic [31:0] ld_addr;
  logic [15:0] ld_data, jump_to;
  logic        ld_ready, mem_we, fetch_valid, flush, fault;
  logic [31:0] mem_addr, pc;
  logic [15:0] mem_wdata;
  logic [1:0]  state;

  logic        s_start, s_halt, s_jv;
  logic [7:0]  s_jt;
  logic        s_ld_ready, s_mem_we, s_fv, s_flush, s_fault;
  logic [7:0]  s_mem_addr, s_pc;
  logic [15:0] s_wdata;
  logic [1:0]  s_state;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] fq[$];
  logic [47:0] wq[$];
  logic [31:0] exp_pc;
  logic [47:0] exp_w;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_last(ld_last),
    .ld_addr(ld_addr), .ld_data(ld_data), .start(start), .halt_req(halt_req), .stall(stall),
    .jump_valid(jump_valid), .jump_to(jump_to), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .pc(pc), .fetch_valid(fetch_valid), .flush(flush), .state(state),
    .fault(fault)
  );

  fetch_sequencer #(
    .ADDR_W(8), .DATA_W(16), .JUMP_W(8), .RESET_VEC(8'h20), .IMEM_DEPTH(64)
  ) dut8 (
    .clk(clk), .rst(rst), .ld_valid(1'b0), .ld_ready(s_ld_ready), .ld_last(1'b0),
    .ld_addr(8'h00), .ld_data(16'h0000), .start(s_start), .halt_req(s_halt), .stall(1'b0),
    .jump_valid(s_jv), .jump_to(s_jt), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
    .mem_wdata(s_wdata), .pc(s_pc), .fetch_valid(s_fv), .flush(s_flush), .state(s_state),
    .fault(s_fault)
  );

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input logic [47:0] act);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual=%0h expected=nothing queued", name, act);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every presented fetch or memory write must match the head of its queue
  always @(negedge clk) begin
    if (rst) begin
      if (fetch_valid) begin
        if (fq.size() == 0) begin
          flag("fetch_unexpected", 48'(pc));
        end else begin
          exp_pc = fq.pop_front();
          check("fetch_pc", 48'(pc), 48'(exp_pc));
        end
      end
      if (mem_we) begin
        if (wq.size() == 0) begin
          flag("write_unexpected", {mem_addr, mem_wdata});
        end else begin
          exp_w = wq.pop_front();
          check("mem_write", {mem_addr, mem_wdata}, exp_w);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; ld_addr = 32'h0; ld_data = 16'h0;
    start = 1'b0; halt_req = 1'b0; stall = 1'b0; jump_valid = 1'b0; jump_to = 16'h0;
    s_start = 1'b0; s_halt = 1'b0; s_jv = 1'b0; s_jt = 8'h00;
    #1 rst = 1'b0;
    #1;
    check("rst_state", 48'(state), 48'h0);
    check("rst_pc", 48'(pc), 48'h20);
    check("rst_fetch_valid", 48'(fetch_valid), 48'h0);
    check("rst_flush", 48'(flush), 48'h0);
    check("rst_fault", 48'(fault), 48'h0);
    step; step;
    rst = 1'b1;

    // Program load: 3 beats, the IDLE cycle beat is not accepted
    ld_valid = 1'b1; ld_addr = 32'h20; ld_data = 16'hA000;
    @(negedge clk);
    check("idle_ld_ready", 48'(ld_ready), 48'h0);
    check("idle_mem_we", 48'(mem_we), 48'h0);
    step;
    wq.push_back({32'h20, 16'hA000});
    @(negedge clk);
    check("load_state", 48'(state), 48'h1);
    step;
    ld_addr = 32'h21; ld_data = 16'hA001; start = 1'b1;
    wq.push_back({32'h21, 16'hA001});
    @(negedge clk);
    check("load_ignores_start", 48'(state), 48'h1);
    check("load_mem_addr", 48'(mem_addr), 48'h21);
    step;
    start = 1'b0; ld_addr = 32'h22; ld_data = 16'hA002; ld_last = 1'b1;
    wq.push_back({32'h22, 16'hA002});
    for (int i = 0; i < 6; i++) fq.push_back(32'h20 + 32'(i));
    step;
    ld_valid = 1'b0; ld_last = 1'b0;
    @(negedge clk);
    check("run_state", 48'(state), 48'h2);
    check("run_first_pc", 48'(pc), 48'h20);
    repeat (5) step;

    // Jump beats stall, one bubble follows
    stall = 1'b1; jump_valid = 1'b1; jump_to = 16'h0040;
    step;
    stall = 1'b0; jump_valid = 1'b0;
    @(negedge clk);
    check("jump_pc", 48'(pc), 48'h40);
    check("jump_flush", 48'(flush), 48'h1);
    check("jump_bubble", 48'(fetch_valid), 48'h0);
    fq.push_back(32'h41);
    step;
    @(negedge clk);
    check("flush_pulse_end", 48'(flush), 48'h0);
    check("post_jump_fv", 48'(fetch_valid), 48'h1);
    jump_valid = 1'b1; jump_to = 16'h002F;
    step;
    jump_valid = 1'b0;
    repeat (5) fq.push_back(32'h30);
    fq.push_back(32'h31);
    step;

    // Stall for 4 cycles at 0x30 with loader traffic that must be ignored
    stall = 1'b1; ld_valid = 1'b1; ld_addr = 32'h99;
    @(negedge clk);
    check("run_mem_we", 48'(mem_we), 48'h0);
    check("run_ld_ready", 48'(ld_ready), 48'h0);
    check("run_mem_addr", 48'(mem_addr), 48'h30);
    repeat (4) step;
    stall = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    check("stall_hold_pc", 48'(pc), 48'h30);
    step;
    halt_req = 1'b1;
    step;
    halt_req = 1'b0;
    @(negedge clk);
    check("halt_state", 48'(state), 48'h0);
    check("halt_pc", 48'(pc), 48'h31);
    check("halt_fv", 48'(fetch_valid), 48'h0);

    // Start without loading, then asynchronous reset mid-run
    start = 1'b1;
    fq.push_back(32'h20);
    fq.push_back(32'h21);
    step;
    start = 1'b0;
    step;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_state", 48'(state), 48'h0);
    check("async_rst_pc", 48'(pc), 48'h20);
    check("async_rst_fv", 48'(fetch_valid), 48'h0);
    step;
    rst = 1'b1;

`ifdef FETCH_BOUNDS_CHECK_EN
    s_start = 1'b1;
    step;
    s_start = 1'b0; s_jv = 1'b1; s_jt = 8'h40;
    step;
    s_jv = 1'b0;
    @(negedge clk);
    check("bounds_state", 48'(s_state), 48'h3);
    check("bounds_fault", 48'(s_fault), 48'h1);
    check("bounds_fv", 48'(s_fv), 48'h0);
    check("bounds_pc_held", 48'(s_pc), 48'h20);
    s_start = 1'b1; s_halt = 1'b1; s_jv = 1'b1; s_jt = 8'h10;
    repeat (3) step;
    s_start = 1'b0; s_halt = 1'b0; s_jv = 1'b0;
    @(negedge clk);
    check("fault_sticky_state", 48'(s_state), 48'h3);
    check("fault_sticky_flag", 48'(s_fault), 48'h1);
    #2 rst = 1'b0;
    #1;
    check("fault_rst_state", 48'(s_state), 48'h0);
    check("fault_rst_flag", 48'(s_fault), 48'h0);
    step;
    rst = 1'b1;
`else
    s_start = 1'b1;
    step;
    s_start = 1'b0; s_jv = 1'b1; s_jt = 8'hFE;
    step;
    s_jv = 1'b0;
    step;
    @(negedge clk);
    check("wrap_pre_pc", 48'(s_pc), 48'hFF);
    check("wrap_pre_fv", 48'(s_fv), 48'h1);
    step;
    @(negedge clk);
    check("wrap_pc", 48'(s_pc), 48'h00);
    check("wrap_state", 48'(s_state), 48'h2);
    check("wrap_no_fault", 48'(s_fault), 48'h0);
    s_halt = 1'b1;
    step;
    s_halt = 1'b0;
`endif

    step; step;
    check("fetch_queue_drained", 48'(fq.size()), 48'h0);
    check("write_queue_drained", 48'(wq.size()), 48'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
